// File: rtl/pll_pkg.sv
// pll_pkg: shared widths, loop-filter state type and the clamp used by the error accumulator and PI stage
package pll_pkg;
  localparam int ERR_W_D = 8;
  localparam int CTRL_W_D = 12;
  typedef enum logic [1:0] {IDLE, ACCUM, APPLY} lf_state_t;
  function automatic int clamp(input int x, input int lo, input int hi);
    return x < lo ? lo : (x > hi ? hi : x);
  endfunction
endpackage

// File: rtl/pll_loop_filter_if.sv
// pll_loop_filter_if: PFD/reference inputs and oscillator control outputs of the loop filter
// master drives link/up/dn/enable and observes ctrl/ctrl_valid/err/locked/sat; slave is the filter
interface pll_loop_filter_if import pll_pkg::*; #(
  parameter int ERR_W = ERR_W_D,
  parameter int CTRL_W = CTRL_W_D
);
  logic link, up, dn, enable;
  logic [CTRL_W-1:0] ctrl;
  logic ctrl_valid;
  logic signed [ERR_W-1:0] err;
  logic locked, sat;
  modport master (output link, up, dn, enable, input ctrl, ctrl_valid, err, locked, sat);
  modport slave (input link, up, dn, enable, output ctrl, ctrl_valid, err, locked, sat);
endinterface

// File: rtl/pll_sync_edge.sv
// pll_sync_edge: 2-flop synchronizer with optional registered rising-edge strobe
// clk/fv_rst: clock and async reset; d: async input; q: synchronized level; rise: 1-cycle strobe 3 clk after a d rising edge
module pll_sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic fv_rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [2:0] sr;
  always_ff @(posedge clk or posedge fv_rst)
    if (fv_rst) begin
      sr <= '0;
      rise <= 1'b0;
    end else begin
      sr <= {sr[1:0], d};
      rise <= EDGE & sr[1] & ~sr[2];
    end
  assign q = sr[1];
endmodule

// File: rtl/pll_loop_filter.sv
// pll_loop_filter: PI loop filter integrating PFD up/dn per reference window into an oscillator control word
// clk/fv_rst: sampling clock and async active-high reset; bus: link/up/dn/enable in, ctrl/ctrl_valid/err/locked/sat out
module pll_loop_filter import pll_pkg::*; #(
  parameter int ERR_W = ERR_W_D,
  parameter int CTRL_W = CTRL_W_D,
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 0,
  parameter int CTRL_INIT = 2048,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input logic clk,
  input logic fv_rst,
  pll_loop_filter_if.slave bus
);
  localparam int ERR_MAX = 2**(ERR_W-1) - 1;
  localparam int CTRL_MAX = 2**CTRL_W - 1;
  localparam int LC_W = $clog2(LOCK_CNT + 1);
  logic up_s, dn_s, ref_tick, unused_up_rise, unused_dn_rise, unused_link_q;
  lf_state_t state;
  logic signed [ERR_W-1:0] cnt;
  logic [CTRL_W-1:0] integ;
  logic [LC_W-1:0] lock_cnt, lock_n;
  logic pend, tick, in_tol;
  int delta, cnt_n, integ_r, integ_n, ctrl_r, ctrl_n, err_abs;

  pll_sync_edge #(.EDGE(1'b0)) u_up (.clk(clk), .fv_rst(fv_rst), .d(bus.up), .q(up_s), .rise(unused_up_rise));
  pll_sync_edge #(.EDGE(1'b0)) u_dn (.clk(clk), .fv_rst(fv_rst), .d(bus.dn), .q(dn_s), .rise(unused_dn_rise));
  pll_sync_edge #(.EDGE(1'b1)) u_link (.clk(clk), .fv_rst(fv_rst), .d(bus.link), .q(unused_link_q), .rise(ref_tick));

  // a tick landing in APPLY is parked in pend and closes the window on the next ACCUM cycle
  always_comb begin
    delta = (up_s & ~dn_s) ? 1 : (dn_s & ~up_s) ? -1 : 0;
    cnt_n = clamp(int'(cnt) + delta, -ERR_MAX, ERR_MAX);
    tick = ref_tick | pend;
    integ_r = int'(integ) + (int'(bus.err) <<< KI_SHIFT);
    integ_n = clamp(integ_r, 0, CTRL_MAX);
    ctrl_r = integ_n + (int'(bus.err) <<< KP_SHIFT);
    ctrl_n = clamp(ctrl_r, 0, CTRL_MAX);
    err_abs = bus.err < 0 ? -int'(bus.err) : int'(bus.err);
    in_tol = err_abs <= LOCK_TOL;
    lock_n = !in_tol ? '0 : (lock_cnt == LC_W'(LOCK_CNT) ? lock_cnt : lock_cnt + 1'b1);
  end

  // clamping the integrator itself (not just ctrl) is the anti-windup
  always_ff @(posedge clk or posedge fv_rst)
    if (fv_rst) begin
      state <= IDLE;
      cnt <= '0;
      pend <= 1'b0;
      integ <= CTRL_W'(CTRL_INIT);
      lock_cnt <= '0;
      bus.ctrl <= CTRL_W'(CTRL_INIT);
      bus.err <= '0;
      bus.ctrl_valid <= 1'b0;
      bus.locked <= 1'b0;
      bus.sat <= 1'b0;
    end else begin
      bus.ctrl_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          pend <= 1'b0;
          lock_cnt <= '0;
          bus.locked <= 1'b0;
          if (bus.enable && ref_tick) state <= ACCUM;
        end
        ACCUM:
          if (!bus.enable) begin
            state <= IDLE;
            cnt <= '0;
            pend <= 1'b0;
            lock_cnt <= '0;
            bus.locked <= 1'b0;
          end else if (tick) begin
            bus.err <= ERR_W'(cnt_n);
            cnt <= '0;
            pend <= 1'b0;
            state <= APPLY;
          end else cnt <= ERR_W'(cnt_n);
        APPLY: begin
          integ <= CTRL_W'(integ_n);
          bus.ctrl <= CTRL_W'(ctrl_n);
          bus.sat <= (integ_n != integ_r) || (ctrl_n != ctrl_r);
          bus.ctrl_valid <= 1'b1;
          cnt <= bus.enable ? ERR_W'(cnt_n) : '0;
          pend <= bus.enable & ref_tick;
          lock_cnt <= bus.enable ? lock_n : '0;
          bus.locked <= bus.enable && lock_n == LC_W'(LOCK_CNT);
          state <= bus.enable ? ACCUM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pll_loop_filter.sv
// tb_pll_loop_filter: directed-vector bench for pll_loop_filter
module tb_pll_loop_filter;
  logic clk = 1'b0;
  logic fv_rst;
  int n_cmp = 0, n_bad = 0;
  int nv, v_at, v_ctrl, v_err, v_integ, v_sat, v_locked, cnt_at_drop, nv0, integ_m, ctrl_m;

  pll_loop_filter_if bus ();
  pll_loop_filter dut (.clk(clk), .fv_rst(fv_rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one link period: link high for the first half, pulses start 4 clk after the link edge
  task automatic window(input int period, input int n_both, input int n_up, input int n_dn, input int drop_at = -1);
    for (int i = 0; i < period; i++) begin
      @(negedge clk);
      bus.link = i < period / 2;
      bus.up = (i - 4 >= 0) && (i - 4 < n_both + n_up);
      bus.dn = (i - 4 >= 0) && ((i - 4 < n_both) || (i - 4 >= n_both + n_up && i - 4 < n_both + n_up + n_dn));
      if (i == drop_at) begin
        cnt_at_drop = int'(dut.cnt);
        bus.enable = 1'b0;
      end
      if (bus.ctrl_valid) begin
        nv++;
        v_at = i;
        v_ctrl = int'(bus.ctrl);
        v_err = int'(bus.err);
        v_integ = int'(dut.integ);
        v_sat = int'(bus.sat);
        v_locked = int'(bus.locked);
      end
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 fv_rst = 1'b1;
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fv_rst = 1'b1;
    bus.link = 1'b0;
    bus.up = 1'b0;
    bus.dn = 1'b0;
    bus.enable = 1'b0;
    nv = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", int'(bus.ctrl), 2048);
    chk("rst_integ", int'(dut.integ), 2048);
    chk("rst_valid", int'(bus.ctrl_valid), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_sat", int'(bus.sat), 0);
    fv_rst = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    window(40, 0, 10, 0);
    chk("first_win_no_update", nv, 0);
    window(40, 0, 10, 0);
    chk("single_nvalid", nv, 1);
    chk("single_valid_at", v_at, 5);
    chk("single_err", v_err, 10);
    chk("single_integ", v_integ, 2058);
    chk("single_ctrl", v_ctrl, 2098);
    chk("single_sat", v_sat, 0);
    async_reset();
    chk("arst_ctrl", int'(bus.ctrl), 2048);
    chk("arst_integ", int'(dut.integ), 2048);
    chk("arst_err", int'(bus.err), 0);
    chk("arst_valid", int'(bus.ctrl_valid), 0);
    chk("arst_locked", int'(bus.locked), 0);
    chk("arst_sat", int'(bus.sat), 0);
    @(negedge clk) fv_rst = 1'b0;
    nv = 0;
    window(40, 10, 0, 4);
    window(40, 0, 0, 0);
    chk("ovl_nvalid", nv, 1);
    chk("ovl_err", v_err, -4);
    chk("ovl_integ", v_integ, 2044);
    chk("ovl_ctrl", v_ctrl, 2028);
    async_reset();
    @(negedge clk) fv_rst = 1'b0;
    nv = 0;
    integ_m = 2048;
    for (int k = 0; k < 19; k++) begin
      window(256, 0, 200, 0);
      if (k > 0) begin
        integ_m = integ_m + 127 > 4095 ? 4095 : integ_m + 127;
        ctrl_m = integ_m + 508 > 4095 ? 4095 : integ_m + 508;
        chk("climb_ctrl", v_ctrl, ctrl_m);
      end
    end
    chk("sat_nvalid", nv, 18);
    chk("sat_err", v_err, 127);
    chk("sat_integ", v_integ, 4095);
    chk("sat_ctrl", v_ctrl, 4095);
    chk("sat_flag", v_sat, 1);
    window(256, 0, 0, 10);
    window(40, 0, 0, 0);
    chk("unwind_err", v_err, -10);
    chk("unwind_integ", v_integ, 4085);
    chk("unwind_ctrl", v_ctrl, 4045);
    chk("unwind_sat", v_sat, 0);
    async_reset();
    @(negedge clk) fv_rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 17; k++) begin
      window(40, 0, 2, 0);
      if (k == 15) chk("lock_15th", v_locked, 0);
    end
    chk("lock_16th", v_locked, 1);
    chk("lock_integ", v_integ, 2080);
    chk("lock_ctrl", v_ctrl, 2088);
    window(40, 0, 3, 0);
    chk("lock_hold", v_locked, 1);
    window(40, 0, 0, 0);
    chk("unlock_err", v_err, 3);
    chk("unlock_locked", v_locked, 0);
    chk("unlock_integ", v_integ, 2085);
    chk("unlock_ctrl", v_ctrl, 2097);
    for (int k = 0; k < 16; k++) begin
      window(40, 0, 2, 0);
      if (k == 14) chk("relock_15th", v_locked, 0);
    end
    chk("relock_16th", v_locked, 1);
    chk("relock_integ", v_integ, 2115);
    nv0 = nv;
    window(40, 0, 5, 0, 20);
    chk("drop_last_locked", v_locked, 1);
    chk("drop_last_ctrl", v_ctrl, 2125);
    chk("drop_cnt", cnt_at_drop, 5);
    chk("drop_locked", int'(bus.locked), 0);
    chk("drop_nvalid", nv, nv0 + 1);
    window(40, 0, 3, 0);
    chk("off_nvalid", nv, nv0 + 1);
    chk("off_ctrl", int'(bus.ctrl), 2125);
    bus.enable = 1'b1;
    window(40, 0, 3, 0);
    chk("reen_open_only", nv, nv0 + 1);
    window(40, 0, 0, 0);
    chk("reen_nvalid", nv, nv0 + 2);
    chk("reen_err", v_err, 3);
    chk("reen_integ", v_integ, 2120);
    chk("reen_ctrl", v_ctrl, 2132);
    chk("reen_locked", v_locked, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
